// File: rtl/pipe_pkg.sv
// ----------------------------------------------------------------------------
// pipe_pkg
//
// Shared definitions for the fetch/decode pipeline register.
//   NOP      : all-zero instruction word (decode treats it as "no operation").
//   IMM_FLAG : bit index that marks an opcode word as the first half of a
//              two-word instruction (the MSB of a 16-bit word).
//   state_t  : if_id_buffer FSM encoding.
//                S_OP  - the next word from fetch is an opcode.
//                S_IMM - the next word from fetch is the immediate of a held
//                        opcode.
// ----------------------------------------------------------------------------
package pipe_pkg;

    localparam logic [15:0] NOP      = 16'b0;
    localparam int          IMM_FLAG = 15;

    typedef enum logic {
        S_OP  = 1'b0,
        S_IMM = 1'b1
    } state_t;

endpackage : pipe_pkg

// File: rtl/pipe_reg.sv
// ----------------------------------------------------------------------------
// pipe_reg
//
// Generic pipeline register with load enable and synchronous clear.
// Clear wins over enable, so a flush empties the register even while the
// pipeline is stalled.
//
// Parameters
//   WIDTH  : register width in bits.
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset (register -> 0)
//   i_en   in   load i_d on the next rising edge
//   i_clr  in   synchronous clear to 0 (priority over i_en)
//   i_d    in   WIDTH  data to load
//   o_q    out  WIDTH  registered value
// ----------------------------------------------------------------------------
module pipe_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule : pipe_reg

// File: rtl/if_id_buffer.sv
// ----------------------------------------------------------------------------
// if_id_buffer
//
// Fetch -> decode pipeline register. Single-word instructions pass through
// with one cycle of latency. A two-word instruction (opcode with its MSB set,
// followed by a 16-bit immediate word) is reassembled: the opcode is parked in
// holding registers while a bubble goes to decode, and the complete packet is
// issued when the immediate word arrives on the following fetch cycle.
// The hazard unit can stall (freeze everything) or flush (clear the packet
// and abandon any half-built instruction); flush wins over stall.
//
// Parameters
//   W          instruction / immediate word width (default 16)
//   AW         PC width (default 2*W)
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   instr_f    in   W   instruction word from fetch (NOP on fetch flush/branch)
//   imm_f      in   W   raw memory word at the fetch PC, never masked
//   pc_f       in   AW  PC of the word being fetched
//   pc_1_f     in   AW  pc_f + 1
//   stall      in   hold state and outputs this cycle
//   flush      in   discard the current and any pending instruction
//   instr_d    out  W   opcode word to decode
//   imm_d      out  W   immediate of a two-word instruction, else 0
//   pc_d       out  AW  PC of the opcode word
//   pc_next_d  out  AW  PC after the last word of the instruction
//   valid_d    out  packet on *_d is a real instruction
//   imm_wait   out  an opcode is held, waiting for its immediate word
// ----------------------------------------------------------------------------
module if_id_buffer
    import pipe_pkg::*;
#(
    parameter int W  = 16,
    parameter int AW = 2 * W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  instr_f,
    input  logic [W-1:0]  imm_f,
    input  logic [AW-1:0] pc_f,
    input  logic [AW-1:0] pc_1_f,
    input  logic          stall,
    input  logic          flush,
    output logic [W-1:0]  instr_d,
    output logic [W-1:0]  imm_d,
    output logic [AW-1:0] pc_d,
    output logic [AW-1:0] pc_next_d,
    output logic          valid_d,
    output logic          imm_wait
);

    // Packet layout: {instr, imm, pc, pc_next, valid}
    localparam int PKT_W  = 2 * W + 2 * AW + 1;
    localparam int HOLD_W = W + AW;

    state_t             r_state;
    state_t             w_state_next;

    logic               w_is_two_word;
    logic               w_run;
    logic               w_hold_load;
    logic [PKT_W-1:0]   w_pkt_next;
    logic [PKT_W-1:0]   w_pkt_q;
    logic [HOLD_W-1:0]  w_hold_q;
    logic [W-1:0]       w_hold_instr;
    logic [AW-1:0]      w_hold_pc;

    // The flag bit is the word MSB; for the default 16-bit word this is
    // IMM_FLAG.
    assign w_is_two_word = instr_f[W-1];
    assign w_run         = ~stall;

    assign w_hold_instr  = w_hold_q[HOLD_W-1 -: W];
    assign w_hold_pc     = w_hold_q[AW-1:0];

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_OP;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next state, holding-register load and next decode packet.
    // The packet mux depends only on the current state; stall and flush act
    // through the register enable/clear so the same packet logic serves both.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_hold_load  = 1'b0;
        w_pkt_next   = '0;

        case (r_state)
            S_OP: begin
                if (w_is_two_word) begin
                    // Park the opcode; the all-zero packet is the bubble.
                    w_hold_load = w_run;
                    if (w_run) begin
                        w_state_next = S_IMM;
                    end
                end else begin
                    w_pkt_next = {instr_f, {W{1'b0}}, pc_f, pc_1_f,
                                  (instr_f != W'(NOP))};
                end
            end
            S_IMM: begin
                // The arriving word is data; its MSB is deliberately ignored.
                w_pkt_next = {w_hold_instr, imm_f, w_hold_pc, pc_1_f, 1'b1};
                if (w_run) begin
                    w_state_next = S_OP;
                end
            end
            default: begin
                w_state_next = S_OP;
            end
        endcase

        if (flush) begin
            w_state_next = S_OP;
            w_hold_load  = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Holding registers for the opcode word and its PC
    // ------------------------------------------------------------------------
    pipe_reg #(
        .WIDTH (HOLD_W)
    ) u_hold (
        .clk   (clk),
        .rst_n (rst),
        .i_en  (w_hold_load),
        .i_clr (flush),
        .i_d   ({instr_f, pc_f}),
        .o_q   (w_hold_q)
    );

    // ------------------------------------------------------------------------
    // Registered decode packet
    // ------------------------------------------------------------------------
    pipe_reg #(
        .WIDTH (PKT_W)
    ) u_out (
        .clk   (clk),
        .rst_n (rst),
        .i_en  (w_run),
        .i_clr (flush),
        .i_d   (w_pkt_next),
        .o_q   (w_pkt_q)
    );

    assign {instr_d, imm_d, pc_d, pc_next_d, valid_d} = w_pkt_q;
    assign imm_wait = (r_state == S_IMM);

endmodule : if_id_buffer

// File: tb/tb_if_id_buffer.sv
module tb_if_id_buffer;

    localparam int W  = 16;
    localparam int AW = 32;
    localparam int OW = 2 * W + 2 * AW + 2;

    logic          clk;
    logic          rst;
    logic [W-1:0]  instr_f;
    logic [W-1:0]  imm_f;
    logic [AW-1:0] pc_f;
    logic [AW-1:0] pc_1_f;
    logic          stall;
    logic          flush;
    logic [W-1:0]  instr_d;
    logic [W-1:0]  imm_d;
    logic [AW-1:0] pc_d;
    logic [AW-1:0] pc_next_d;
    logic          valid_d;
    logic          imm_wait;

    int checks = 0;
    int errors = 0;

    // Reference model: what decode should see, plus the instruction that is
    // half-assembled (opcode waiting for its immediate), if any.
    logic [W-1:0]  e_instr, e_imm;
    logic [AW-1:0] e_pc, e_pcn;
    logic          e_valid;
    bit            m_pending;
    logic [W-1:0]  m_op;
    logic [AW-1:0] m_op_pc;

    if_id_buffer #(.W(W), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .instr_f   (instr_f),
        .imm_f     (imm_f),
        .pc_f      (pc_f),
        .pc_1_f    (pc_1_f),
        .stall     (stall),
        .flush     (flush),
        .instr_d   (instr_d),
        .imm_d     (imm_d),
        .pc_d      (pc_d),
        .pc_next_d (pc_next_d),
        .valid_d   (valid_d),
        .imm_wait  (imm_wait)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [OW-1:0] obs();
        return {instr_d, imm_d, pc_d, pc_next_d, valid_d, imm_wait};
    endfunction

    function automatic logic [OW-1:0] exp_pkt();
        return {e_instr, e_imm, e_pc, e_pcn, e_valid, logic'(m_pending)};
    endfunction

    task automatic model_reset();
        e_instr = '0; e_imm = '0; e_pc = '0; e_pcn = '0; e_valid = 1'b0;
        m_pending = 1'b0; m_op = '0; m_op_pc = '0;
    endtask

    task automatic model_step();
        if (flush) begin
            model_reset();
        end else if (!stall) begin
            if (m_pending) begin
                e_instr = m_op; e_imm = imm_f; e_pc = m_op_pc;
                e_pcn = pc_1_f; e_valid = 1'b1;
                m_pending = 1'b0;
            end else if (instr_f >= 16'h8000) begin
                m_pending = 1'b1; m_op = instr_f; m_op_pc = pc_f;
                e_instr = '0; e_imm = '0; e_pc = '0; e_pcn = '0; e_valid = 1'b0;
            end else begin
                e_instr = instr_f; e_imm = '0; e_pc = pc_f;
                e_pcn = pc_f + 1; e_valid = (instr_f != 0);
            end
        end
    endtask

    // Advance one clock: model sees the same inputs the DUT samples; outputs
    // are then looked at 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input logic [W-1:0] ins, input logic [W-1:0] imm,
                         input logic [AW-1:0] pc);
        instr_f = ins;
        imm_f   = imm;
        pc_f    = pc;
        pc_1_f  = pc + 1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        drive(16'h0000, 16'h0000, 0);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (obs() !== '0) begin
            errors++;
            $display("FAIL reset_init got %h required 0", obs());
        end
        @(posedge clk); @(posedge clk);
        #2 rst = 1'b1;
        model_reset();
    endtask

    task automatic test_single();
        drive(16'h1234, 16'h5A5A, 5);
        tick();
        checks++;
        if (obs() !== {16'h1234, 16'h0000, 32'd5, 32'd6, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL single_word got %h required %h", obs(),
                     {16'h1234, 16'h0000, 32'd5, 32'd6, 1'b1, 1'b0});
        end
        drive(16'h0000, 16'h1111, 6);
        tick();
        checks++;
        if (valid_d !== 1'b0 || pc_d !== 32'd6 || imm_wait !== 1'b0) begin
            errors++;
            $display("FAIL nop_word got valid %b pc %0d wait %b required 0 6 0",
                     valid_d, pc_d, imm_wait);
        end
    endtask

    task automatic test_two_word();
        drive(16'h8A01, 16'h8A01, 10);
        tick();
        checks++;
        if (valid_d !== 1'b0 || instr_d !== 16'h0 || imm_wait !== 1'b1) begin
            errors++;
            $display("FAIL two_word_bubble got valid %b instr %h wait %b required 0 0000 1",
                     valid_d, instr_d, imm_wait);
        end
        drive(16'hBEEF, 16'hBEEF, 11);
        tick();
        checks++;
        if (obs() !== {16'h8A01, 16'hBEEF, 32'd10, 32'd12, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL two_word_pkt got %h required %h", obs(),
                     {16'h8A01, 16'hBEEF, 32'd10, 32'd12, 1'b1, 1'b0});
        end
    endtask

    task automatic test_imm_flag_data();
        drive(16'h8123, 16'h8123, 20);
        tick();
        drive(16'hFFFF, 16'hFFFF, 21);
        tick();
        checks++;
        if (obs() !== {16'h8123, 16'hFFFF, 32'd20, 32'd22, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL imm_msb_pkt got %h required %h", obs(),
                     {16'h8123, 16'hFFFF, 32'd20, 32'd22, 1'b1, 1'b0});
        end
        drive(16'h0001, 16'h0001, 22);
        tick();
        checks++;
        if (obs() !== {16'h0001, 16'h0000, 32'd22, 32'd23, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL imm_msb_next got %h required %h", obs(),
                     {16'h0001, 16'h0000, 32'd22, 32'd23, 1'b1, 1'b0});
        end
    endtask

    task automatic test_stall_imm();
        drive(16'h8055, 16'h8055, 30);
        tick();
        stall = 1'b1;
        drive(16'h0042, 16'h0042, 31);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (valid_d !== 1'b0 || instr_d !== 16'h0 || imm_wait !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold[%0d] got valid %b instr %h wait %b required 0 0000 1",
                         i, valid_d, instr_d, imm_wait);
            end
        end
        stall = 1'b0;
        tick();
        checks++;
        if (obs() !== {16'h8055, 16'h0042, 32'd30, 32'd32, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL stall_release got %h required %h", obs(),
                     {16'h8055, 16'h0042, 32'd30, 32'd32, 1'b1, 1'b0});
        end
    endtask

    task automatic test_flush_stall();
        drive(16'h8077, 16'h8077, 40);
        tick();
        stall = 1'b1; flush = 1'b1;
        drive(16'h9999, 16'h9999, 41);
        tick();
        checks++;
        if (obs() !== '0) begin
            errors++;
            $display("FAIL flush_in_imm got %h required 0", obs());
        end
        stall = 1'b0; flush = 1'b0;
        drive(16'h0001, 16'h0001, 42);
        tick();
        checks++;
        if (obs() !== {16'h0001, 16'h0000, 32'd42, 32'd43, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL after_flush got %h required %h", obs(),
                     {16'h0001, 16'h0000, 32'd42, 32'd43, 1'b1, 1'b0});
        end
    endtask

    task automatic test_async_reset();
        drive(16'h8ABC, 16'h8ABC, 50);
        tick();
        drive(16'h1357, 16'h1357, 51);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (obs() !== '0) begin
            errors++;
            $display("FAIL async_reset got %h required 0", obs());
        end
        @(posedge clk);
        #2 rst = 1'b1;
        model_reset();
        drive(16'h0777, 16'h0777, 60);
        tick();
        checks++;
        if (obs() !== {16'h0777, 16'h0000, 32'd60, 32'd61, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL post_reset got %h required %h", obs(),
                     {16'h0777, 16'h0000, 32'd60, 32'd61, 1'b1, 1'b0});
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] pc;
        logic [W-1:0]  w;
        pc = 32'h100;
        for (int i = 0; i < 400; i++) begin
            stall = ($urandom_range(0, 9) < 2);
            flush = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 3))
                0:       w = 16'h0000;
                1:       w = 16'h8000 | 16'($urandom);
                default: w = 16'($urandom);
            endcase
            drive(w, w, pc);
            if (i % 50 == 0) imm_f = 16'($urandom);
            tick();
            checks++;
            if (obs() !== exp_pkt()) begin
                errors++;
                $display("FAIL random[%0d] got %h required %h", i, obs(), exp_pkt());
            end
            if (!stall) pc = pc + 1;
        end
        stall = 1'b0; flush = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_two_word();
        test_imm_flag_data();
        test_stall_imm();
        test_flush_stall();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_if_id_buffer
